// File: rtl/buffer_xbar.sv
// rtl/buffer_xbar.sv - snooper/CPU/forwarder to N packet buffer crossbar with ordered ownership
module buffer_xbar #(
  parameter int N_BUFS     = 3,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int INC_WIDTH  = 8,
  parameter int PLEN_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          sn_addr,
  input  logic [DATA_WIDTH-1:0]          sn_wr_data,
  input  logic                           sn_wr_en,
  input  logic [INC_WIDTH-1:0]           sn_bytes_inc,
  input  logic                           sn_reset_len,
  input  logic                           sn_done,
  output logic                           sn_rdy,
  input  logic [ADDR_WIDTH-1:0]          cpu_addr,
  input  logic                           cpu_rd_en,
  input  logic                           cpu_acc,
  input  logic                           cpu_rej,
  output logic [DATA_WIDTH-1:0]          cpu_rd_data,
  output logic                           cpu_rd_data_vld,
  output logic [PLEN_WIDTH-1:0]          cpu_len,
  output logic                           cpu_rdy,
  input  logic [ADDR_WIDTH-1:0]          fwd_addr,
  input  logic                           fwd_rd_en,
  input  logic                           fwd_done,
  output logic [DATA_WIDTH-1:0]          fwd_rd_data,
  output logic                           fwd_rd_data_vld,
  output logic [PLEN_WIDTH-1:0]          fwd_len,
  output logic                           fwd_rdy,
  output logic [N_BUFS*ADDR_WIDTH-1:0]   buf_addr,
  output logic [N_BUFS*DATA_WIDTH-1:0]   buf_wr_data,
  output logic [N_BUFS*INC_WIDTH-1:0]    buf_bytes_inc,
  output logic [N_BUFS-1:0]              buf_wr_en,
  output logic [N_BUFS-1:0]              buf_reset_len,
  output logic [N_BUFS-1:0]              buf_rd_en,
  input  logic [N_BUFS*DATA_WIDTH-1:0]   buf_rd_data,
  input  logic [N_BUFS-1:0]              buf_rd_data_vld,
  input  logic [N_BUFS*PLEN_WIDTH-1:0]   buf_len
);

  localparam int PTR_WIDTH = (N_BUFS > 1) ? $clog2(N_BUFS) : 1;

  typedef enum logic [2:0] {
    FREE, SN_OWN, WAIT_CPU, CPU_OWN, WAIT_FWD, FWD_OWN, REJ
  } buf_state_e;

  buf_state_e             st [N_BUFS];
  logic [PTR_WIDTH-1:0]   sn_ptr, cpu_ptr, fwd_ptr;
  logic [DATA_WIDTH-1:0]  rd_data_a [N_BUFS];
  logic [PLEN_WIDTH-1:0]  len_a     [N_BUFS];

  // Explicit wrap so non-power-of-two buffer counts rotate correctly
  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(N_BUFS - 1)) ? '0 : p + 1'b1;
  endfunction

  // Unpack the flattened per-buffer return buses for pointer indexing
  always_comb begin
    for (int i = 0; i < N_BUFS; i++) begin
      rd_data_a[i] = buf_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      len_a[i]     = buf_len[i*PLEN_WIDTH +: PLEN_WIDTH];
    end
  end

  // Ownership FSM per buffer plus the three rotating agent pointers; each agent
  // only ever touches the buffer its pointer names, in a state only it can act on
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_BUFS; i++) st[i] <= FREE;
      sn_ptr  <= '0;
      cpu_ptr <= '0;
      fwd_ptr <= '0;
      sn_rdy  <= 1'b0;
      cpu_rdy <= 1'b0;
      fwd_rdy <= 1'b0;
    end else begin
      if (sn_rdy) begin
        if (sn_done) begin
          st[sn_ptr] <= WAIT_CPU;
          sn_ptr     <= next_ptr(sn_ptr);
          sn_rdy     <= 1'b0;
        end
      end else if (st[sn_ptr] == FREE) begin
        st[sn_ptr] <= SN_OWN;
        sn_rdy     <= 1'b1;
      end

      if (cpu_rdy) begin
        if (cpu_acc || cpu_rej) begin
          st[cpu_ptr] <= cpu_rej ? REJ : WAIT_FWD;
          cpu_ptr     <= next_ptr(cpu_ptr);
          cpu_rdy     <= 1'b0;
        end
      end else if (st[cpu_ptr] == WAIT_CPU) begin
        st[cpu_ptr] <= CPU_OWN;
        cpu_rdy     <= 1'b1;
      end

      if (fwd_rdy) begin
        if (fwd_done) begin
          st[fwd_ptr] <= FREE;
          fwd_ptr     <= next_ptr(fwd_ptr);
          fwd_rdy     <= 1'b0;
        end
      end else if (st[fwd_ptr] == WAIT_FWD) begin
        st[fwd_ptr] <= FWD_OWN;
        fwd_rdy     <= 1'b1;
      end else if (st[fwd_ptr] == REJ) begin
        st[fwd_ptr] <= FREE;
        fwd_ptr     <= next_ptr(fwd_ptr);
      end
    end
  end

  // Route each owning agent onto its buffer slice; everything else stays zero
  always_comb begin
    buf_addr      = '0;
    buf_wr_data   = '0;
    buf_bytes_inc = '0;
    buf_wr_en     = '0;
    buf_reset_len = '0;
    buf_rd_en     = '0;
    for (int i = 0; i < N_BUFS; i++) begin
      if (sn_rdy && sn_ptr == PTR_WIDTH'(i)) begin
        buf_addr[i*ADDR_WIDTH +: ADDR_WIDTH]    = sn_addr;
        buf_wr_data[i*DATA_WIDTH +: DATA_WIDTH] = sn_wr_data;
        buf_bytes_inc[i*INC_WIDTH +: INC_WIDTH] = sn_bytes_inc;
        buf_wr_en[i]                            = sn_wr_en;
        buf_reset_len[i]                        = sn_reset_len;
      end
      if (cpu_rdy && cpu_ptr == PTR_WIDTH'(i)) begin
        buf_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = cpu_addr;
        buf_rd_en[i]                         = cpu_rd_en;
      end
      if (fwd_rdy && fwd_ptr == PTR_WIDTH'(i)) begin
        buf_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = fwd_addr;
        buf_rd_en[i]                         = fwd_rd_en;
      end
    end
  end

  // Registered read return from whichever buffer each reader points at
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rd_data     <= '0;
      cpu_rd_data_vld <= 1'b0;
      cpu_len         <= '0;
      fwd_rd_data     <= '0;
      fwd_rd_data_vld <= 1'b0;
      fwd_len         <= '0;
    end else begin
      cpu_rd_data     <= rd_data_a[cpu_ptr];
      cpu_rd_data_vld <= cpu_rdy & buf_rd_data_vld[cpu_ptr];
      cpu_len         <= cpu_rdy ? len_a[cpu_ptr] : '0;
      fwd_rd_data     <= rd_data_a[fwd_ptr];
      fwd_rd_data_vld <= fwd_rdy & buf_rd_data_vld[fwd_ptr];
      fwd_len         <= fwd_rdy ? len_a[fwd_ptr] : '0;
    end
  end

endmodule

// File: tb/tb_buffer_xbar.sv
// tb/tb_buffer_xbar.sv - self-checking bench for buffer_xbar (3 and 5 buffers)
module tb_buffer_xbar;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- 3-buffer instance ----------------
  logic [8:0]   a_sn_addr, a_cpu_addr, a_fwd_addr;
  logic [63:0]  a_sn_wr_data;
  logic [7:0]   a_sn_bytes_inc;
  logic         a_sn_wr_en, a_sn_reset_len, a_sn_done, a_sn_rdy;
  logic         a_cpu_rd_en, a_cpu_acc, a_cpu_rej, a_cpu_rd_data_vld, a_cpu_rdy;
  logic         a_fwd_rd_en, a_fwd_done, a_fwd_rd_data_vld, a_fwd_rdy;
  logic [63:0]  a_cpu_rd_data, a_fwd_rd_data;
  logic [31:0]  a_cpu_len, a_fwd_len;
  logic [26:0]  a_buf_addr;
  logic [191:0] a_buf_wr_data, a_buf_rd_data;
  logic [23:0]  a_buf_bytes_inc;
  logic [2:0]   a_buf_wr_en, a_buf_reset_len, a_buf_rd_en, a_buf_rd_data_vld;
  logic [95:0]  a_buf_len;

  buffer_xbar #(.N_BUFS(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .sn_addr(a_sn_addr), .sn_wr_data(a_sn_wr_data), .sn_wr_en(a_sn_wr_en),
    .sn_bytes_inc(a_sn_bytes_inc), .sn_reset_len(a_sn_reset_len), .sn_done(a_sn_done), .sn_rdy(a_sn_rdy),
    .cpu_addr(a_cpu_addr), .cpu_rd_en(a_cpu_rd_en), .cpu_acc(a_cpu_acc), .cpu_rej(a_cpu_rej),
    .cpu_rd_data(a_cpu_rd_data), .cpu_rd_data_vld(a_cpu_rd_data_vld), .cpu_len(a_cpu_len), .cpu_rdy(a_cpu_rdy),
    .fwd_addr(a_fwd_addr), .fwd_rd_en(a_fwd_rd_en), .fwd_done(a_fwd_done),
    .fwd_rd_data(a_fwd_rd_data), .fwd_rd_data_vld(a_fwd_rd_data_vld), .fwd_len(a_fwd_len), .fwd_rdy(a_fwd_rdy),
    .buf_addr(a_buf_addr), .buf_wr_data(a_buf_wr_data), .buf_bytes_inc(a_buf_bytes_inc),
    .buf_wr_en(a_buf_wr_en), .buf_reset_len(a_buf_reset_len), .buf_rd_en(a_buf_rd_en),
    .buf_rd_data(a_buf_rd_data), .buf_rd_data_vld(a_buf_rd_data_vld), .buf_len(a_buf_len)
  );

  // ---------------- 5-buffer instance ----------------
  logic [8:0]   b_sn_addr, b_cpu_addr, b_fwd_addr;
  logic [63:0]  b_sn_wr_data;
  logic [7:0]   b_sn_bytes_inc;
  logic         b_sn_wr_en, b_sn_reset_len, b_sn_done, b_sn_rdy;
  logic         b_cpu_rd_en, b_cpu_acc, b_cpu_rej, b_cpu_rd_data_vld, b_cpu_rdy;
  logic         b_fwd_rd_en, b_fwd_done, b_fwd_rd_data_vld, b_fwd_rdy;
  logic [63:0]  b_cpu_rd_data, b_fwd_rd_data;
  logic [31:0]  b_cpu_len, b_fwd_len;
  logic [44:0]  b_buf_addr;
  logic [319:0] b_buf_wr_data, b_buf_rd_data;
  logic [39:0]  b_buf_bytes_inc;
  logic [4:0]   b_buf_wr_en, b_buf_reset_len, b_buf_rd_en, b_buf_rd_data_vld;
  logic [159:0] b_buf_len;

  buffer_xbar #(.N_BUFS(5)) dut5 (
    .clk(clk), .rst_n(rst_n),
    .sn_addr(b_sn_addr), .sn_wr_data(b_sn_wr_data), .sn_wr_en(b_sn_wr_en),
    .sn_bytes_inc(b_sn_bytes_inc), .sn_reset_len(b_sn_reset_len), .sn_done(b_sn_done), .sn_rdy(b_sn_rdy),
    .cpu_addr(b_cpu_addr), .cpu_rd_en(b_cpu_rd_en), .cpu_acc(b_cpu_acc), .cpu_rej(b_cpu_rej),
    .cpu_rd_data(b_cpu_rd_data), .cpu_rd_data_vld(b_cpu_rd_data_vld), .cpu_len(b_cpu_len), .cpu_rdy(b_cpu_rdy),
    .fwd_addr(b_fwd_addr), .fwd_rd_en(b_fwd_rd_en), .fwd_done(b_fwd_done),
    .fwd_rd_data(b_fwd_rd_data), .fwd_rd_data_vld(b_fwd_rd_data_vld), .fwd_len(b_fwd_len), .fwd_rdy(b_fwd_rdy),
    .buf_addr(b_buf_addr), .buf_wr_data(b_buf_wr_data), .buf_bytes_inc(b_buf_bytes_inc),
    .buf_wr_en(b_buf_wr_en), .buf_reset_len(b_buf_reset_len), .buf_rd_en(b_buf_rd_en),
    .buf_rd_data(b_buf_rd_data), .buf_rd_data_vld(b_buf_rd_data_vld), .buf_len(b_buf_len)
  );

  // Packet memories of the 5-buffer instance: each holds the id last written into it
  logic [31:0] mem5 [5];
  always_comb begin
    b_buf_len = '0;
    for (int i = 0; i < 5; i++) b_buf_len[i*32 +: 32] = mem5[i];
  end

  // ---------------- directed vector table (3 buffers) ----------------
  typedef struct {
    logic [6:0]  ctl;   // sn_done, sn_wr_en, cpu_acc, cpu_rej, cpu_rd_en, fwd_done, fwd_rd_en
    logic [8:0]  sa, ca, fa;
    logic [2:0]  rdy;   // sn, cpu, fwd
    logic [2:0]  wr, rd;
    logic [26:0] ea;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t v(input logic [6:0] ctl, input int sa, input int ca, input int fa,
                             input logic [2:0] rdy, input logic [2:0] wr, input logic [2:0] rd,
                             input int ea);
    vec_t r;
    r.ctl = ctl; r.sa = 9'(sa); r.ca = 9'(ca); r.fa = 9'(fa);
    r.rdy = rdy; r.wr = wr; r.rd = rd; r.ea = 27'(ea);
    return r;
  endfunction

  // ---------------- counting reference model (5 buffers) ----------------
  // Packet p lives in buffer p % N. s/c/f count packets released by snooper,
  // CPU and forwarder (rejects counted when skipped).
  int          s, c, f;
  bit          m_sn, m_cpu, m_fwd;
  bit          rej_hist [4096];
  logic [31:0] exp_fl, exp_cl;

  task automatic model_reset();
    s = 0; c = 0; f = 0;
    m_sn = 0; m_cpu = 0; m_fwd = 0;
    exp_fl = 0; exp_cl = 0;
  endtask

  task automatic run5(input int mode, input int cycles, input int stop_f);
    int ns, nc, nf;
    bit nsn, ncpu, nfwd;
    logic [4:0] ew, er;
    int r;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      if (stop_f > 0 && f >= stop_f) break;
      b_sn_wr_en   = 1'b1;
      b_sn_wr_data = 64'(s + 1);
      b_sn_addr    = 9'($urandom);
      b_cpu_addr   = 9'($urandom);
      b_fwd_addr   = 9'($urandom);
      b_cpu_rd_en  = 1'($urandom);
      b_fwd_rd_en  = 1'($urandom);
      if (mode == 0) begin
        b_sn_done  = m_sn;
        b_cpu_acc  = m_cpu && (c % 2 == 0);
        b_cpu_rej  = m_cpu && (c % 2 == 1);
        b_fwd_done = m_fwd;
      end else begin
        r = $urandom_range(0, 5);
        b_sn_done  = ($urandom_range(0, 3) == 0);
        b_cpu_acc  = (r == 0) || (r == 2);
        b_cpu_rej  = (r == 1) || (r == 2);
        b_fwd_done = ($urandom_range(0, 2) == 0);
      end
      #1;
      ew = (b_sn_wr_en && m_sn) ? (5'b1 << (s % 5)) : 5'b0;
      er = ((b_cpu_rd_en && m_cpu) ? (5'b1 << (c % 5)) : 5'b0)
         | ((b_fwd_rd_en && m_fwd) ? (5'b1 << (f % 5)) : 5'b0);
      chk("b_sn_rdy",  b_sn_rdy,  m_sn);
      chk("b_cpu_rdy", b_cpu_rdy, m_cpu);
      chk("b_fwd_rdy", b_fwd_rdy, m_fwd);
      chk("b_wr_en",   b_buf_wr_en, ew);
      chk("b_rd_en",   b_buf_rd_en, er);
      chk("b_fwd_len", b_fwd_len, exp_fl);
      chk("b_cpu_len", b_cpu_len, exp_cl);
      for (int i = 0; i < 5; i++)
        if (b_buf_wr_en[i]) mem5[i] = b_buf_wr_data[i*64 +: 32];
      ns = s; nc = c; nf = f; nsn = m_sn; ncpu = m_cpu; nfwd = m_fwd;
      if (m_sn && b_sn_done) begin ns = s + 1; nsn = 0; end
      else if (!m_sn && (s - f) < 5) nsn = 1;
      if (m_cpu && (b_cpu_acc || b_cpu_rej)) begin
        rej_hist[c % 4096] = b_cpu_rej;
        nc = c + 1; ncpu = 0;
      end else if (!m_cpu && c < s) ncpu = 1;
      if (m_fwd && b_fwd_done) begin nf = f + 1; nfwd = 0; end
      else if (!m_fwd && f < c) begin
        if (rej_hist[f % 4096]) nf = f + 1;
        else nfwd = 1;
      end
      exp_fl = m_fwd ? 32'(f + 1) : 32'd0;
      exp_cl = m_cpu ? 32'(c + 1) : 32'd0;
      @(negedge clk);
      s = ns; c = nc; f = nf; m_sn = nsn; m_cpu = ncpu; m_fwd = nfwd;
    end
  endtask

  task automatic chk_a_zero(input string tag);
    chk({tag, "_rdys"},  {a_sn_rdy, a_cpu_rdy, a_fwd_rdy}, 0);
    chk({tag, "_vlds"},  {a_cpu_rd_data_vld, a_fwd_rd_data_vld}, 0);
    chk({tag, "_cdata"}, a_cpu_rd_data, 0);
    chk({tag, "_lens"},  {a_cpu_len, a_fwd_len}, 0);
    chk({tag, "_baddr"}, 64'(a_buf_addr), 0);
    chk({tag, "_bstrb"}, {a_buf_wr_en, a_buf_rd_en, a_buf_reset_len}, 0);
    chk({tag, "_bwdat"}, 64'(|a_buf_wr_data), 0);
    chk({tag, "_b5rdy"}, {b_sn_rdy, b_cpu_rdy, b_fwd_rdy}, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    {a_sn_addr, a_cpu_addr, a_fwd_addr, a_sn_wr_data, a_sn_bytes_inc} = '0;
    {a_sn_wr_en, a_sn_reset_len, a_sn_done, a_cpu_rd_en, a_cpu_acc, a_cpu_rej, a_fwd_rd_en, a_fwd_done} = '0;
    a_buf_rd_data = '0; a_buf_rd_data_vld = '0; a_buf_len = '0;
    {b_sn_addr, b_cpu_addr, b_fwd_addr, b_sn_wr_data, b_sn_bytes_inc} = '0;
    {b_sn_wr_en, b_sn_reset_len, b_sn_done, b_cpu_rd_en, b_cpu_acc, b_cpu_rej, b_fwd_rd_en, b_fwd_done} = '0;
    b_buf_rd_data = '0; b_buf_rd_data_vld = '0;
    for (int i = 0; i < 5; i++) mem5[i] = '0;

    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0100000, 5, 0, 0, 3'b100, 3'b001, 3'b000, 5));
    tbl.push_back(v(7'b1000000, 0, 0, 0, 3'b100, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0010000, 0, 0, 0, 3'b110, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b100, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000011, 0, 0, 9, 3'b101, 3'b000, 3'b001, 9));
    tbl.push_back(v(7'b1000000, 0, 0, 0, 3'b100, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b1011000, 0, 0, 0, 3'b110, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0101000, 7, 0, 0, 3'b110, 3'b001, 3'b000, 7));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b100, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b1000000, 0, 0, 0, 3'b100, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b1000000, 0, 0, 0, 3'b110, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b1000000, 0, 0, 0, 3'b110, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b1000100, 0, 3, 0, 3'b010, 3'b000, 3'b001, 3));
    tbl.push_back(v(7'b0001000, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b000, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0000000, 0, 0, 0, 3'b010, 3'b000, 3'b000, 0));
    tbl.push_back(v(7'b0100100, 1, 2, 0, 3'b110, 3'b001, 3'b010, 1025));

    repeat (3) @(negedge clk);
    chk_a_zero("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      {a_sn_done, a_sn_wr_en, a_cpu_acc, a_cpu_rej, a_cpu_rd_en, a_fwd_done, a_fwd_rd_en} = tbl[i].ctl;
      a_sn_addr  = tbl[i].sa;
      a_cpu_addr = tbl[i].ca;
      a_fwd_addr = tbl[i].fa;
      #1;
      chk($sformatf("row%0d_rdy", i),   {a_sn_rdy, a_cpu_rdy, a_fwd_rdy}, tbl[i].rdy);
      chk($sformatf("row%0d_wr_en", i), a_buf_wr_en, tbl[i].wr);
      chk($sformatf("row%0d_rd_en", i), a_buf_rd_en, tbl[i].rd);
      chk($sformatf("row%0d_addr", i),  a_buf_addr, tbl[i].ea);
      @(negedge clk);
    end

    // CPU owns buffer 1: read return one cycle after the buffer presents data
    {a_sn_done, a_sn_wr_en, a_cpu_acc, a_cpu_rej, a_cpu_rd_en, a_fwd_done, a_fwd_rd_en} = '0;
    a_cpu_rd_en = 1'b1;
    a_cpu_addr  = 9'd4;
    a_buf_rd_data[64 +: 64] = 64'hDEAD_BEEF;
    a_buf_rd_data_vld       = 3'b010;
    a_buf_len[32 +: 32]     = 32'd77;
    @(negedge clk);
    chk("rd_data", a_cpu_rd_data, 64'hDEAD_BEEF);
    chk("rd_vld",  a_cpu_rd_data_vld, 1);
    chk("rd_len",  a_cpu_len, 77);
    chk("rd_en1",  a_buf_rd_en, 3'b010);
    chk("fwd_vld_idle", a_fwd_rd_data_vld, 0);

    // Asynchronous reset in the middle of the read clears everything at once
    #2 rst_n = 1'b0;
    #1 chk_a_zero("midrst");
    a_buf_rd_data_vld = '0;
    a_cpu_rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    model_reset();
    run5(0, 400, 12);
    chk("wrap_12_packets", 64'(f >= 12), 1);
    run5(1, 2000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
